// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg
//   Shared definitions for the MIPS hazard/forwarding controller.
//   - fwd_e: forwarding mux select encoding used by both the ID and EX muxes
//   - DEF_*: default widths and multiply/divide latencies
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    FW_NONE = 2'b00,
    FW_M    = 2'b01,
    FW_W    = 2'b10
  } fwd_e;

  localparam int DEF_AW      = 5;
  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 32;
  localparam int DEF_CNT_W   = 6;
  localparam int DEF_PERF_W  = 32;

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// md_busy_counter
//   Tracks how long HI/LO stays occupied by an in-flight multiply or divide.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     i_start        EX instruction issues a multiply/divide this cycle
//     i_is_div       qualifies i_start: 1 = divide, 0 = multiply
//     i_mem_wait     pipeline frozen; an issue is not accepted while frozen
//     o_busy         HI/LO result still pending
module md_busy_counter #(
  parameter int CNT_W   = 6,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_is_div,
  input  logic i_mem_wait,
  output logic o_busy
);

  logic [CNT_W-1:0] r_count;

  // An accepted issue reloads the latency (even if already busy, which is an
  // illegal program but must not wedge the counter). The countdown keeps
  // running through a memory freeze because the multiplier is not frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_start && !i_mem_wait) begin
      r_count <= i_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_busy = (r_count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard detection and forwarding control for the 5-stage MIPS pipeline.
//   Ports:
//     clk, rst_n                    clock, asynchronous active-low reset
//     i_RsD/i_RtD, i_RsE/i_RtE      source registers in ID / EX
//     i_RegAddr{E,M,W}              destination registers in EX/MEM/WB
//     i_RegWrite{E,M,W}             destination write enables
//     i_MemtoReg{E,M}               instruction in EX/MEM is a load
//     i_BranchUseD, i_BranchTakenD  ID branch compares registers / is taken
//     i_LikelyD                     ID instruction is a branch-likely
//     i_MdUseD                      ID instruction touches HI/LO
//     i_MdStartE, i_MdIsDivE        EX issues a multiply/divide
//     i_MemWait                     data memory not ready (freeze)
//     i_PerfClr                     synchronous clear of the stall counter
//     o_Forward_{A,B}_{D,E}         forwarding mux selects (fwd_e encoding)
//     o_Stall_*, o_Flush_*          pipeline register holds / bubbles
//     o_Md_Busy                     HI/LO result pending
//     o_Stall_Cycles                saturating count of Stall_PC cycles
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PERF_W  = DEF_PERF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     i_RsD,
  input  logic [AW-1:0]     i_RtD,
  input  logic [AW-1:0]     i_RsE,
  input  logic [AW-1:0]     i_RtE,
  input  logic [AW-1:0]     i_RegAddrE,
  input  logic [AW-1:0]     i_RegAddrM,
  input  logic [AW-1:0]     i_RegAddrW,
  input  logic              i_RegWriteE,
  input  logic              i_RegWriteM,
  input  logic              i_RegWriteW,
  input  logic              i_MemtoRegE,
  input  logic              i_MemtoRegM,
  input  logic              i_BranchUseD,
  input  logic              i_BranchTakenD,
  input  logic              i_LikelyD,
  input  logic              i_MdUseD,
  input  logic              i_MdStartE,
  input  logic              i_MdIsDivE,
  input  logic              i_MemWait,
  input  logic              i_PerfClr,
  output logic [1:0]        o_Forward_A_D,
  output logic [1:0]        o_Forward_B_D,
  output logic [1:0]        o_Forward_A_E,
  output logic [1:0]        o_Forward_B_E,
  output logic              o_Stall_PC,
  output logic              o_Stall_IF_ID,
  output logic              o_Stall_ID_EX,
  output logic              o_Stall_EX_MEM,
  output logic              o_Stall_MEM_WB,
  output logic              o_Flush_IF_ID,
  output logic              o_Flush_ID_EX,
  output logic              o_Md_Busy,
  output logic [PERF_W-1:0] o_Stall_Cycles
);

  logic w_srcMatchE;
  logic w_srcMatchM;
  logic w_loadUse;
  logic w_branchHaz;
  logic w_mdHaz;
  logic w_stall;
  logic w_freeze;
  logic w_mdBusy;

  logic [PERF_W-1:0] r_stallCycles;

  // MEM is younger than WB, so its value wins when both write the register.
  function automatic fwd_e fwdSel(input logic [AW-1:0] src);
    fwd_e sel;
    sel = FW_NONE;
    if (src == '0)
      sel = FW_NONE;
    else if (i_RegWriteM && (src == i_RegAddrM))
      sel = FW_M;
    else if (i_RegWriteW && (src == i_RegAddrW))
      sel = FW_W;
    return sel;
  endfunction

  assign o_Forward_A_D = fwdSel(i_RsD);
  assign o_Forward_B_D = fwdSel(i_RtD);
  assign o_Forward_A_E = fwdSel(i_RsE);
  assign o_Forward_B_E = fwdSel(i_RtE);

  assign w_srcMatchE = (i_RegAddrE != '0) && ((i_RsD == i_RegAddrE) || (i_RtD == i_RegAddrE));
  assign w_srcMatchM = (i_RegAddrM != '0) && ((i_RsD == i_RegAddrM) || (i_RtD == i_RegAddrM));

  // A branch compares in ID, so it cannot take a value still being computed
  // in EX, nor a load result that only appears at the end of MEM.
  assign w_loadUse   = i_MemtoRegE && w_srcMatchE;
  assign w_branchHaz = i_BranchUseD && ((i_RegWriteE && w_srcMatchE) ||
                                        (i_MemtoRegM && w_srcMatchM));
  assign w_mdHaz     = i_MdUseD && (w_mdBusy || i_MdStartE);

  assign w_stall  = w_loadUse || w_branchHaz || w_mdHaz;
  assign w_freeze = i_MemWait;

  // Freeze holds every stage; a stall holds the front end and injects a
  // bubble into EX. A stalled branch-likely is only squashed once it resolves.
  assign o_Stall_PC     = w_freeze || w_stall;
  assign o_Stall_IF_ID  = w_freeze || w_stall;
  assign o_Stall_ID_EX  = w_freeze;
  assign o_Stall_EX_MEM = w_freeze;
  assign o_Stall_MEM_WB = w_freeze;
  assign o_Flush_ID_EX  = w_stall && !w_freeze;
  assign o_Flush_IF_ID  = i_LikelyD && !i_BranchTakenD && !w_stall && !w_freeze;

  md_busy_counter #(
    .CNT_W   (CNT_W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_MdStartE),
    .i_is_div   (i_MdIsDivE),
    .i_mem_wait (i_MemWait),
    .o_busy     (w_mdBusy)
  );

  assign o_Md_Busy = w_mdBusy;

  // Clear wins over counting; the counter sticks at all-ones once full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCycles <= '0;
    end else if (i_PerfClr) begin
      r_stallCycles <= '0;
    end else if (o_Stall_PC && (r_stallCycles != '1)) begin
      r_stallCycles <= r_stallCycles + PERF_W'(1);
    end
  end

  assign o_Stall_Cycles = r_stallCycles;

endmodule
